// File: rtl/frame_tx_if.sv
// frame_tx_if -- pixel stream in / raster stream out bundle for frame_tx.
//   startFrame  : request one frame (sampled only while idle)
//   PixIn/PixValid/PixReady : upstream byte push handshake
//   FrameOut/IncIndex       : transmitted byte and its valid strobe
//   PxOut/LineOut/FrameRInd : raster position and linear index
//   FrameDone/Busy          : end-of-frame pulse, not-idle flag
// master = upstream source / receiver side, slave = frame_tx.
interface frame_tx_if;
  logic        startFrame;
  logic [7:0]  PixIn;
  logic        PixValid;
  logic        PixReady;
  logic [7:0]  FrameOut;
  logic        IncIndex;
  logic [9:0]  PxOut;
  logic [9:0]  LineOut;
  logic [15:0] FrameRInd;
  logic        FrameDone;
  logic        Busy;

  modport master (
    output startFrame, PixIn, PixValid,
    input  PixReady, FrameOut, IncIndex, PxOut, LineOut, FrameRInd,
           FrameDone, Busy
  );

  modport slave (
    input  startFrame, PixIn, PixValid,
    output PixReady, FrameOut, IncIndex, PxOut, LineOut, FrameRInd,
           FrameDone, Busy
  );
endinterface

// File: rtl/frame_tx.sv
// frame_tx -- buffers upstream pixel bytes in a small FIFO and plays them out
// as a raster of H_ACTIVE x V_ACTIVE pixels with H_BLANK idle cycles after
// every line and V_BLANK further idle cycles after the last line.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active high
//   tx    : frame_tx_if.slave (push handshake in, raster stream out)
// PxOut/LineOut give the position of the next pixel to be popped;
// FrameRInd is registered together with FrameOut and names that byte.
module frame_tx #(
  parameter int H_ACTIVE   = 330,
  parameter int V_ACTIVE   = 110,
  parameter int H_BLANK    = 4,
  parameter int V_BLANK    = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  frame_tx_if.slave   tx
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int BLK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BLK_W   = $clog2(BLK_MAX + 1);

  localparam logic [9:0]       PX_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]       LINE_LAST = 10'(V_ACTIVE - 1);
  localparam logic [BLK_W-1:0] H_LAST    = BLK_W'(H_BLANK - 1);
  localparam logic [BLK_W-1:0] V_LAST    = BLK_W'(V_BLANK - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_e;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push, pop, empty, ready;

  // Readiness is purely occupancy based: a pop in the same cycle does not
  // open a slot for the byte on the input, it is taken next cycle.
  assign ready = (cnt_q < CNT_FULL);
  assign empty = (cnt_q == '0);
  assign push  = tx.PixValid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= tx.PixIn;
  end

  // -------------------------------------------------------------- raster
  state_e           state_q, state_d;
  logic [9:0]       px_q, px_d;
  logic [9:0]       line_q, line_d;
  logic [15:0]      idx_q, idx_d;     // linear index of next pixel to pop
  logic [BLK_W-1:0] blk_q, blk_d;     // cycles spent in current blanking
  logic [7:0]       fo_q, fo_d;
  logic [15:0]      fri_q, fri_d;
  logic             inc_q, inc_d;
  logic             done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      px_q    <= '0;
      line_q  <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      fo_q    <= '0;
      fri_q   <= '0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      fo_q    <= fo_d;
      fri_q   <= fri_d;
      inc_q   <= inc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    line_d  = line_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    fo_d    = fo_q;
    fri_d   = fri_q;
    inc_d   = 1'b0;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx.startFrame) begin
          state_d = ACTIVE;
          px_d    = '0;
          line_d  = '0;
          idx_d   = '0;
          fri_d   = '0;
        end
      end
      ACTIVE: begin
        // An empty FIFO simply stalls the raster in place.
        if (!empty) begin
          pop   = 1'b1;
          inc_d = 1'b1;
          fo_d  = mem_q[rd_ptr_q];
          fri_d = idx_q;
          idx_d = idx_q + 16'd1;
          if (px_q == PX_LAST) begin
            px_d    = '0;
            blk_d   = '0;
            state_d = HBLANK;
          end else begin
            px_d = px_q + 10'd1;
          end
        end
      end
      HBLANK: begin
        if (blk_q == H_LAST) begin
          blk_d = '0;
          if (line_q == LINE_LAST) begin
            state_d = VBLANK;
          end else begin
            line_d  = line_q + 10'd1;
            state_d = ACTIVE;
          end
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      VBLANK: begin
        if (blk_q == V_LAST) begin
          done    = 1'b1;
          state_d = IDLE;
          line_d  = '0;
          idx_d   = '0;
          fri_d   = '0;
          blk_d   = '0;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx.PixReady  = ready;
  assign tx.FrameOut  = fo_q;
  assign tx.IncIndex  = inc_q;
  assign tx.PxOut     = px_q;
  assign tx.LineOut   = line_q;
  assign tx.FrameRInd = fri_q;
  assign tx.FrameDone = done;
  assign tx.Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_frame_tx.sv
module tb_frame_tx;
  localparam int H = 330, V = 110, HB = 4, VB = 2, DEPTH = 16;
  localparam int N = H * V;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_tx_if ifc();

  frame_tx #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB),
             .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .tx(ifc));

  int vec = 0, miscmp = 0;
  int inc_seen = 0, done_seen = 0;

  // Reference: a byte queue plus "pixels popped so far" and "blank cycles
  // still owed"; raster coordinates are derived arithmetically from those.
  logic [7:0] q[$];
  bit         run = 0, m_inc = 0;
  int         n = 0, gap = 0, m_fri = 0;
  logic [7:0] m_fo = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      miscmp++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int  sz;
    bit  was_run, pop, push;
    sz = q.size();
    was_run = run;
    if (reset) begin
      q.delete(); run = 0; n = 0; gap = 0; m_inc = 0; m_fo = 8'h00; m_fri = 0;
    end else begin
      push  = ifc.PixValid && (sz < DEPTH);
      pop   = run && gap == 0 && sz > 0;
      m_inc = pop;
      if (pop) begin
        m_fo  = q.pop_front();
        m_fri = n;
        n++;
        if (n % H == 0) gap = HB + ((n == N) ? VB : 0);
      end else if (run && gap > 0) begin
        gap--;
        if (gap == 0 && n == N) begin run = 0; n = 0; m_fri = 0; end
      end
      if (!was_run && ifc.startFrame) run = 1;
      if (push) q.push_back(ifc.PixIn);
    end
  endtask

  task automatic check_all();
    int line;
    line = (gap > 0) ? (n - 1) / H : n / H;
    chk("FrameOut",  ifc.FrameOut,  m_fo);
    chk("IncIndex",  ifc.IncIndex,  m_inc);
    chk("PxOut",     ifc.PxOut,     n % H);
    chk("LineOut",   ifc.LineOut,   line);
    chk("FrameRInd", ifc.FrameRInd, m_fri);
    chk("FrameDone", ifc.FrameDone, run && gap == 1 && n == N);
    chk("Busy",      ifc.Busy,      run);
    chk("PixReady",  ifc.PixReady,  q.size() < DEPTH);
    if (ifc.IncIndex)  inc_seen++;
    if (ifc.FrameDone) done_seen++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; ifc.startFrame = 1'b0; ifc.PixValid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int cyc;
    ifc.startFrame = 1'b0; ifc.PixValid = 1'b0; ifc.PixIn = 8'h00;

    // Reset state
    do_reset();
    step();

    // Preload 0x00..0x0F, push attempts while full are refused, then drain
    for (int i = 0; i < 16; i++) begin
      ifc.PixValid = 1'b1; ifc.PixIn = 8'(i); step();
    end
    ifc.PixIn = 8'hEE; step(); step();
    ifc.PixValid = 1'b0; ifc.startFrame = 1'b1; step();
    ifc.startFrame = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("stall_px", ifc.PxOut, 16);
    chk("stall_inc", ifc.IncIndex, 0);

    // Full FIFO with a byte held on the input across the first pops
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ifc.PixValid = 1'b1; ifc.PixIn = 8'($urandom); step();
    end
    ifc.PixIn = 8'hAA; ifc.startFrame = 1'b1; step();
    ifc.startFrame = 1'b0;
    for (int i = 0; i < 3; i++) step();
    ifc.PixValid = 1'b0;
    for (int i = 0; i < 25; i++) step();

    // Full frame, PixValid always high, stray startFrame pulses mid-frame
    do_reset();
    inc_seen = 0; done_seen = 0;
    ifc.PixValid = 1'b1; ifc.PixIn = 8'($urandom); ifc.startFrame = 1'b1; step();
    cyc = 0;
    while (done_seen == 0 && cyc < 40000) begin
      ifc.PixIn = 8'($urandom);
      ifc.startFrame = ($urandom_range(0, 7) == 0);
      step();
      cyc++;
    end
    ifc.startFrame = 1'b0;
    chk("frame_done_seen", done_seen, 1);
    for (int i = 0; i < 6; i++) begin ifc.PixIn = 8'($urandom); step(); end
    chk("inc_total", inc_seen, N);
    chk("done_total", done_seen, 1);
    chk("idle_after", ifc.Busy, 0);

    // Alternating PixValid up to line 5 pixel 100, then reset mid-frame
    do_reset();
    ifc.PixValid = 1'b0; ifc.startFrame = 1'b1; step();
    ifc.startFrame = 1'b0;
    cyc = 0;
    while (!(n == 5 * H + 100 && gap == 0) && cyc < 20000) begin
      ifc.PixValid = ~ifc.PixValid; ifc.PixIn = 8'($urandom); step();
      cyc++;
    end
    chk("pre_rst_px", ifc.PxOut, 100);
    chk("pre_rst_line", ifc.LineOut, 5);
    reset = 1'b1; ifc.startFrame = 1'b1; ifc.PixValid = 1'b1; step();
    reset = 1'b0; ifc.startFrame = 1'b0; ifc.PixValid = 1'b0;
    chk("rst_fri", ifc.FrameRInd, 0);
    chk("rst_ready", ifc.PixReady, 1);
    step(); step();

    // Restart with random valid pattern
    ifc.startFrame = 1'b1; step();
    ifc.startFrame = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ifc.PixValid = $urandom_range(0, 1); ifc.PixIn = 8'($urandom); step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
